// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC generation, redirect flush, 2-entry output buffer
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect yields a fault entry and halts fetch)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_ir,
    output logic        out_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam int EW = 65;
`else
    localparam int EW = 64;
`endif

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          pending_q, pending_d;
    logic [31:0]   pend_pc_q, pend_pc_d;
    logic [1:0]    count_q, count_d;
    logic [EW-1:0] ent0_q, ent0_d;
    logic [EW-1:0] ent1_q, ent1_d;

    logic          pop;
    logic          push;
    logic          issue;
    logic          halt;
    logic          trap_push;
    logic [2:0]    occ;
    logic [31:0]   redirect_load_pc;
    logic [EW-1:0] push_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_HALT = 2'd2
    } trap_state_e;

    trap_state_e state_q, state_d;
    logic        misaligned;

    assign misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A newer redirect always overrides a trap or halt in progress.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = misaligned ? ST_TRAP : ST_RUN;
        end else if (state_q == ST_TRAP) begin
            state_d = ST_HALT;
        end
    end

    always_comb begin
        halt      = (state_q != ST_RUN);
        trap_push = (state_q == ST_TRAP) && !redirect_valid;
    end

    // fetch_pc still holds the unaligned target while in ST_TRAP since nothing issues.
    assign redirect_load_pc = redirect_pc;
    assign push_entry       = trap_push ? {1'b1, fetch_pc_q, NOP}
                                        : {1'b0, pend_pc_q, imem_rdata};
    assign out_fault        = ent0_q[64];
`else
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign halt             = 1'b0;
    assign trap_push        = 1'b0;
    assign redirect_load_pc = {redirect_pc[31:2], 2'b00};
    assign push_entry       = {pend_pc_q, imem_rdata};
    assign out_fault        = 1'b0;
`endif

    assign imem_addr = {2'b00, fetch_pc_q[31:2]};
    assign out_valid = (count_q != 2'd0);
    assign out_pc    = ent0_q[63:32];
    assign out_ir    = ent0_q[31:0];

    assign pop  = out_valid && out_ready;
    assign push = !redirect_valid && (pending_q || trap_push);
    assign occ  = {1'b0, count_q} + {2'b00, pending_q};

    // Counting the in-flight response as occupied keeps the buffer from ever overflowing.
    assign issue = !redirect_valid && !halt && ((occ - {2'b00, pop}) < 3'd2);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pending_d  = pending_q;
        pend_pc_d  = pend_pc_q;
        count_d    = count_q;
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_load_pc;
            pending_d  = 1'b0;
            count_d    = 2'd0;
        end else begin
            pending_d = issue;
            if (issue) begin
                pend_pc_d  = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            // Slot 0 is always the head so the outputs come straight from flops.
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent0_d = push_entry;
                    end else begin
                        ent1_d = push_entry;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_d = push_entry;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = push_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            pending_q  <= 1'b0;
            pend_pc_q  <= 32'd0;
            count_q    <= 2'd0;
            ent0_q     <= '0;
            ent1_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pending_q  <= pending_d;
            pend_pc_q  <= pend_pc_d;
            count_q    <= count_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
        end
    end

endmodule
